// File: rtl/conv_window_gen_3x3_pkg.sv
// Shared types and constants for the 3x3 convolution window generator.
// FEATURE_WIDTH defaults to 8 when not supplied on the command line.
`ifndef FEATURE_WIDTH
`define FEATURE_WIDTH 8
`endif

// Width of one packed feature-pair word.
`define CONV_WIN_WORD_W (`FEATURE_WIDTH*2)

package conv_window_gen_3x3_pkg;

  localparam int unsigned WIN_DIM   = 3;
  localparam int unsigned WIN_SLOTS = WIN_DIM * WIN_DIM;
  localparam int unsigned DIM_W     = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/conv_line_buffer.sv
// Simple dual-port line buffer: one write port, one synchronous read port.
// Contents are intentionally not reset.
module conv_line_buffer #(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              system_clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port and registered read port; read data holds when re is low.
  always_ff @(posedge system_clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/conv_window_gen_3x3.sv
// 3x3 sliding-window generator over a row-major stream of feature-pair words.
// Optional build macro: CONV_WINDOW_STRIDE2_EN adds the stride2 input
// (emit only windows whose top-left corner has even row and column).
module conv_window_gen_3x3
  import conv_window_gen_3x3_pkg::*;
#(
  parameter int unsigned FEATURE_WIDTH = `FEATURE_WIDTH,
  parameter int unsigned MAX_ROW       = 1024
) (
  input  logic                                 system_clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic [DIM_W-1:0]                     row_size,
  input  logic [DIM_W-1:0]                     row_count,
`ifdef CONV_WINDOW_STRIDE2_EN
  input  logic                                 stride2,
`endif
  input  logic                                 in_valid,
  input  logic [2*FEATURE_WIDTH-1:0]           in_data,
  output logic                                 in_ready,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [WIN_SLOTS*2*FEATURE_WIDTH-1:0] out_window,
  output logic                                 busy,
  output logic                                 frame_done
);

  localparam int unsigned WORD_W = 2 * FEATURE_WIDTH;
  localparam int unsigned ADDR_W = $clog2(MAX_ROW);

  state_t state_q, state_d;

  logic [DIM_W-1:0] rs_q, rc_q, col_q, row_q;
  logic             stride_on;
  logic             adv, accept, last_pix, emit;

  logic              s1_valid_q, s1_emit_q;
  logic [WORD_W-1:0] s1_pix_q;
  logic [ADDR_W-1:0] s1_col_q;
  logic [WORD_W-1:0] rd0, rd1;

  logic              s2_valid_q;
  logic [WORD_W-1:0] win_q [WIN_SLOTS];
  logic [WIN_SLOTS*WORD_W-1:0] win_flat;

  assign adv      = ~out_valid | out_ready;
  assign accept   = in_valid & in_ready;
  assign last_pix = (row_q == rc_q - 10'd1) && (col_q == rs_q - 10'd1);

`ifdef CONV_WINDOW_STRIDE2_EN
  logic stride_q;

  // Stride mode is fixed for the whole frame.
  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n)                         stride_q <= 1'b0;
    else if (state_q == ST_IDLE && start) stride_q <= stride2;
  end

  assign stride_on = stride_q;
`else
  assign stride_on = 1'b0;
`endif

  // A pixel completes a window once two rows and two columns precede it.
  assign emit = (row_q >= 10'd2) && (col_q >= 10'd2) &&
                (!stride_on || (!row_q[0] && !col_q[0]));

  // State register.
  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = (row_size < 10'd3 || row_count < 10'd3) ? ST_DONE : ST_RUN;
      ST_RUN:   if (accept && last_pix) state_d = ST_DRAIN;
      ST_DRAIN: if (!s1_valid_q && !s2_valid_q && !out_valid) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Status and handshake outputs decoded from the state register.
  always_comb begin
    busy       = 1'b0;
    frame_done = 1'b0;
    in_ready   = 1'b0;
    case (state_q)
      ST_RUN:   begin busy = 1'b1; in_ready = adv; end
      ST_DRAIN: busy = 1'b1;
      ST_DONE:  frame_done = 1'b1;
      default:  ;
    endcase
  end

  // Frame size latch and column/row position of the next accepted pixel.
  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) begin
      rs_q  <= '0;
      rc_q  <= '0;
      col_q <= '0;
      row_q <= '0;
    end else if (state_q == ST_IDLE && start) begin
      rs_q  <= row_size;
      rc_q  <= row_count;
      col_q <= '0;
      row_q <= '0;
    end else if (accept) begin
      if (col_q == rs_q - 10'd1) begin
        col_q <= '0;
        row_q <= row_q + 10'd1;
      end else begin
        col_q <= col_q + 10'd1;
      end
    end
  end

  // Row r-1 lives in buf0, row r-2 in buf1; writes lag reads by one stage.
  conv_line_buffer #(.DEPTH(MAX_ROW), .WIDTH(WORD_W), .ADDR_W(ADDR_W)) u_buf0 (
    .system_clk (system_clk),
    .we         (adv & s1_valid_q),
    .waddr      (s1_col_q),
    .wdata      (s1_pix_q),
    .re         (accept),
    .raddr      (ADDR_W'(col_q)),
    .rdata      (rd0)
  );

  conv_line_buffer #(.DEPTH(MAX_ROW), .WIDTH(WORD_W), .ADDR_W(ADDR_W)) u_buf1 (
    .system_clk (system_clk),
    .we         (adv & s1_valid_q),
    .waddr      (s1_col_q),
    .wdata      (rd0),
    .re         (accept),
    .raddr      (ADDR_W'(col_q)),
    .rdata      (rd1)
  );

  // Three-stage pipeline: capture pixel, shift window column, register output.
  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_emit_q  <= 1'b0;
      s1_pix_q   <= '0;
      s1_col_q   <= '0;
      s2_valid_q <= 1'b0;
      for (int k = 0; k < WIN_SLOTS; k++) win_q[k] <= '0;
      out_valid  <= 1'b0;
      out_window <= '0;
    end else if (adv) begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_pix_q  <= in_data;
        s1_col_q  <= ADDR_W'(col_q);
        s1_emit_q <= emit;
      end
      s2_valid_q <= s1_valid_q & s1_emit_q;
      if (s1_valid_q) begin
        for (int i = 0; i < WIN_DIM; i++) begin
          win_q[WIN_DIM*i]     <= win_q[WIN_DIM*i + 1];
          win_q[WIN_DIM*i + 1] <= win_q[WIN_DIM*i + 2];
        end
        win_q[2] <= rd1;
        win_q[5] <= rd0;
        win_q[8] <= s1_pix_q;
      end
      out_valid <= s2_valid_q;
      if (s2_valid_q) out_window <= win_flat;
    end
  end

  // Flatten window slots into the output word layout.
  always_comb begin
    win_flat = '0;
    for (int k = 0; k < WIN_SLOTS; k++) win_flat[k*WORD_W +: WORD_W] = win_q[k];
  end

endmodule

// File: tb/tb_conv_window_gen_3x3.sv
// Scoreboard bench for conv_window_gen_3x3.
module tb_conv_window_gen_3x3;
  import conv_window_gen_3x3_pkg::*;

  localparam int unsigned WW    = `CONV_WIN_WORD_W;
  localparam int unsigned WIN_W = WIN_SLOTS * WW;

  logic              system_clk = 1'b0;
  logic              rst_n, start, in_valid, in_ready, out_valid, out_ready, busy, frame_done;
  logic [DIM_W-1:0]  row_size, row_count;
  logic [WW-1:0]     in_data;
  logic [WIN_W-1:0]  out_window;
`ifdef CONV_WINDOW_STRIDE2_EN
  logic              stride2;
`endif

  conv_window_gen_3x3 dut (
    .system_clk (system_clk),
    .rst_n      (rst_n),
    .start      (start),
    .row_size   (row_size),
    .row_count  (row_count),
`ifdef CONV_WINDOW_STRIDE2_EN
    .stride2    (stride2),
`endif
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_window (out_window),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 system_clk = ~system_clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int pix_scale = 16;
  bit rnd_mode = 1'b0;
  int win_cnt, done_cnt, first_valid_cyc, acc_cyc;
  bit in_ready_seen;
  bit prev_stall = 1'b0;
  logic [WIN_W-1:0] prev_win;
  logic [WIN_W-1:0] sb_q[$];

  task automatic check_eq(input string tag, input logic [WIN_W-1:0] got, input logic [WIN_W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [WW-1:0] pix(input int r, input int c);
    return WW'(r * pix_scale + c);
  endfunction

  function automatic logic [WIN_W-1:0] exp_win(input int r, input int c);
    logic [WIN_W-1:0] w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[(3*i+j)*WW +: WW] = pix(r - 2 + i, c - 2 + j);
    return w;
  endfunction

  always @(posedge system_clk) cyc <= cyc + 1;

  // Consumer back-pressure: constant ready or a 50% random pattern.
  always @(posedge system_clk) begin
    #1;
    out_ready = rnd_mode ? 1'($urandom_range(1)) : 1'b1;
  end

  // Output monitor: scoreboard pop, stall stability, pulse counting.
  always @(negedge system_clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (in_ready)   in_ready_seen = 1'b1;
      if (frame_done) done_cnt++;
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (prev_stall) begin
        check_eq("stall_valid", WIN_W'(out_valid), WIN_W'(1));
        check_eq("stall_hold", out_window, prev_win);
      end
      if (out_valid && out_ready) begin
        win_cnt++;
        check_eq("sb_nonempty", WIN_W'(sb_q.size() != 0), WIN_W'(1));
        if (sb_q.size() != 0) check_eq("window", out_window, sb_q.pop_front());
      end
      prev_stall = out_valid && !out_ready;
      prev_win   = out_window;
    end
  end

  task automatic run_frame(input int rs, input int rc, input bit strd, input int abort_at);
    int n = 0;
    bit got;
    int exp_cnt;
    win_cnt = 0; done_cnt = 0; first_valid_cyc = -1; acc_cyc = -1;
    @(posedge system_clk); #1;
    row_size = DIM_W'(rs); row_count = DIM_W'(rc); start = 1'b1;
`ifdef CONV_WINDOW_STRIDE2_EN
    stride2 = strd;
`endif
    @(posedge system_clk); #1;
    start = 1'b0;
    @(negedge system_clk);
    check_eq("busy_run", WIN_W'(busy), WIN_W'(1));
    @(posedge system_clk); #1;
    for (int r = 0; r < rc; r++) begin
      for (int c = 0; c < rs; c++) begin
        if (rnd_mode && $urandom_range(3) == 0) begin
          in_valid = 1'b0;
          @(posedge system_clk); #1;
        end
        in_valid = 1'b1;
        in_data  = pix(r, c);
        got = 1'b0;
        for (int w = 0; w < 1000 && !got; w++) begin
          @(negedge system_clk);
          if (in_ready) got = 1'b1;
          else begin @(posedge system_clk); #1; end
        end
        check_eq("accept_wait", WIN_W'(got), WIN_W'(1));
        if (!got) $fatal(1, "input stalled");
        if (r >= 2 && c >= 2 && (!strd || (r % 2 == 0 && c % 2 == 0)))
          sb_q.push_back(exp_win(r, c));
        if (r == 2 && c == 2) acc_cyc = cyc + 1;
        n++;
        @(posedge system_clk); #1;
        in_valid = 1'b0;
        if (n == abort_at) return;
      end
    end
    got = 1'b0;
    for (int w = 0; w < 20000 && !got; w++) begin
      @(negedge system_clk);
      if (done_cnt > 0) got = 1'b1;
    end
    check_eq("frame_done_seen", WIN_W'(got), WIN_W'(1));
    repeat (3) @(negedge system_clk);
    exp_cnt = strd ? ((rs - 1) / 2) * ((rc - 1) / 2) : (rs - 2) * (rc - 2);
    check_eq("done_pulses", WIN_W'(done_cnt), WIN_W'(1));
    check_eq("busy_after", WIN_W'(busy), WIN_W'(0));
    check_eq("sb_empty", WIN_W'(sb_q.size()), WIN_W'(0));
    check_eq("win_count", WIN_W'(win_cnt), WIN_W'(exp_cnt));
    if (!rnd_mode) check_eq("latency", WIN_W'(first_valid_cyc - acc_cyc), WIN_W'(2));
  endtask

  task automatic tiny_frame(input int rs, input int rc);
    win_cnt = 0; done_cnt = 0; in_ready_seen = 1'b0;
    @(posedge system_clk); #1;
    row_size = DIM_W'(rs); row_count = DIM_W'(rc); start = 1'b1; in_valid = 1'b1;
    in_data = pix(0, 0);
    @(posedge system_clk); #1;
    start = 1'b0;
    @(negedge system_clk);
    check_eq("tiny_done_hi", WIN_W'(frame_done), WIN_W'(1));
    check_eq("tiny_busy", WIN_W'(busy), WIN_W'(0));
    @(negedge system_clk);
    check_eq("tiny_done_lo", WIN_W'(frame_done), WIN_W'(0));
    repeat (4) @(negedge system_clk);
    in_valid = 1'b0;
    check_eq("tiny_in_ready", WIN_W'(in_ready_seen), WIN_W'(0));
    check_eq("tiny_windows", WIN_W'(win_cnt), WIN_W'(0));
    check_eq("tiny_pulses", WIN_W'(done_cnt), WIN_W'(1));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
    row_size = '0; row_count = '0; out_ready = 1'b1;
`ifdef CONV_WINDOW_STRIDE2_EN
    stride2 = 1'b0;
`endif
    repeat (3) @(negedge system_clk);
    check_eq("rst_out_valid", WIN_W'(out_valid), WIN_W'(0));
    check_eq("rst_out_window", out_window, WIN_W'(0));
    check_eq("rst_in_ready", WIN_W'(in_ready), WIN_W'(0));
    check_eq("rst_busy", WIN_W'(busy), WIN_W'(0));
    check_eq("rst_frame_done", WIN_W'(frame_done), WIN_W'(0));
    @(posedge system_clk); #1;
    rst_n = 1'b1;

    pix_scale = 16;
    run_frame(5, 5, 1'b0, 0);
    rnd_mode = 1'b1;
    run_frame(5, 5, 1'b0, 0);
    rnd_mode = 1'b0;
    repeat (2) @(posedge system_clk);

    tiny_frame(2, 5);
    tiny_frame(5, 2);

    pix_scale = 1024;
    run_frame(1023, 3, 1'b0, 0);
    pix_scale = 16;

    // Abort mid-row 3 with a window still in flight.
    run_frame(5, 5, 1'b0, 18);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_out_valid", WIN_W'(out_valid), WIN_W'(0));
    check_eq("arst_out_window", out_window, WIN_W'(0));
    check_eq("arst_in_ready", WIN_W'(in_ready), WIN_W'(0));
    check_eq("arst_busy", WIN_W'(busy), WIN_W'(0));
    check_eq("arst_frame_done", WIN_W'(frame_done), WIN_W'(0));
    sb_q.delete();
    @(posedge system_clk); #1;
    rst_n = 1'b1;
    run_frame(5, 5, 1'b0, 0);

`ifdef CONV_WINDOW_STRIDE2_EN
    run_frame(6, 6, 1'b1, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
